// File: rtl/rr_encoder8_3.sv
// Registered round-robin 8:3 encoder/arbiter with a valid/ready grant handshake.
// It returns both the encoded index and the one-hot decode of the winning requester.
module rr_encoder8_3 #(
  parameter int N    = 8,
  parameter int IDXW = 3
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N-1:0]    req,
  input  logic            grant_ready,
  output logic            grant_valid,
  output logic [IDXW-1:0] grant_idx,
  output logic [N-1:0]    grant_onehot
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [IDXW-1:0] ptr_r;
  logic [IDXW-1:0] ptr_s;
  logic            valid_s;
  logic [IDXW-1:0] idx_s;
  logic [N-1:0]    onehot_s;
  logic [N-1:0]    masked_s;
  logic [IDXW-1:0] next_ptr_s;

  // Scan from start upward (mod 8); walking downward lets the lowest offset win.
  function automatic logic [IDXW-1:0] search(input logic [N-1:0] r, input logic [IDXW-1:0] start);
    logic [IDXW-1:0] idx;
    logic [IDXW-1:0] cand;
    idx = 3'd0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = start + IDXW'(k);
      idx  = r[cand] ? cand : idx;
    end
    return idx;
  endfunction

  function automatic logic [N-1:0] decode(input logic [IDXW-1:0] idx);
    return N'(8'd1) << idx;
  endfunction

  assign masked_s   = req & ~grant_onehot;
  assign next_ptr_s = grant_idx + 3'd1;

  // Next-state and next-output selection.
  always_comb begin
    state_s  = state_r;
    ptr_s    = ptr_r;
    valid_s  = grant_valid;
    idx_s    = grant_idx;
    onehot_s = grant_onehot;
    case (state_r)
      IDLE: begin
        if (req != 8'h00) begin
          state_s  = GRANT;
          valid_s  = 1'b1;
          idx_s    = search(req, ptr_r);
          onehot_s = decode(search(req, ptr_r));
        end else begin
          valid_s  = 1'b0;
          idx_s    = 3'd0;
          onehot_s = 8'h00;
        end
      end
      GRANT: begin
        if (grant_ready) begin
          ptr_s = next_ptr_s;
          // The just-accepted requester sits out this one cycle.
          if (masked_s != 8'h00) begin
            state_s  = GRANT;
            valid_s  = 1'b1;
            idx_s    = search(masked_s, next_ptr_s);
            onehot_s = decode(search(masked_s, next_ptr_s));
          end else begin
            state_s  = IDLE;
            valid_s  = 1'b0;
            idx_s    = 3'd0;
            onehot_s = 8'h00;
          end
        end else begin
          state_s = GRANT;
        end
      end
      default: begin
        state_s  = IDLE;
        ptr_s    = 3'd0;
        valid_s  = 1'b0;
        idx_s    = 3'd0;
        onehot_s = 8'h00;
      end
    endcase
  end

  // State, pointer and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      ptr_r        <= 3'd0;
      grant_valid  <= 1'b0;
      grant_idx    <= 3'd0;
      grant_onehot <= 8'h00;
    end else begin
      state_r      <= state_s;
      ptr_r        <= ptr_s;
      grant_valid  <= valid_s;
      grant_idx    <= idx_s;
      grant_onehot <= onehot_s;
    end
  end

endmodule

// File: tb/tb_rr_encoder8_3.sv
// Scenario bench for rr_encoder8_3: expected {valid, idx, onehot} words are queued as
// stimulus is applied and popped for comparison one time unit after each rising edge.
module tb_rr_encoder8_3;

  logic       clk;
  logic       reset_n;
  logic [7:0] req;
  logic       grant_ready;
  logic       grant_valid;
  logic [2:0] grant_idx;
  logic [7:0] grant_onehot;

  logic [11:0] sb[$];
  logic [11:0] exp_w;
  int          total;
  int          passed;

  rr_encoder8_3 dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req          (req),
    .grant_ready  (grant_ready),
    .grant_valid  (grant_valid),
    .grant_idx    (grant_idx),
    .grant_onehot (grant_onehot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "timeout");
  end

  function automatic logic [11:0] ex(input logic v, input logic [2:0] idx);
    logic [7:0] one;
    one = 8'h01;
    return {v, idx, (v ? (one << idx) : 8'h00)};
  endfunction

  task automatic pulse_reset();
    reset_n     = 1'b0;
    req         = 8'h00;
    grant_ready = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n     = 1'b0;
    req         = 8'hFF;
    grant_ready = 1'b0;
    sb.push_back(ex(1'b0, 3'd0));
    @(posedge clk);
    #1;
    exp_w = sb.pop_front();
    total++;
    if ({grant_valid, grant_idx, grant_onehot} !== exp_w)
      $display("FAIL reset_hold: got %h want %h", {grant_valid, grant_idx, grant_onehot}, exp_w);
    else passed++;
    reset_n = 1'b1;
    sb.push_back(ex(1'b1, 3'd0));
    @(posedge clk);
    #1;
    exp_w = sb.pop_front();
    total++;
    if ({grant_valid, grant_idx, grant_onehot} !== exp_w)
      $display("FAIL reset_release: got %h want %h", {grant_valid, grant_idx, grant_onehot}, exp_w);
    else passed++;
  endtask

  // Continues from test_reset: grant 0 is live with all requests high.
  task automatic test_rotation();
    logic [2:0] want [10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2};
    req         = 8'hFF;
    grant_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sb.push_back(ex(1'b1, want[i]));
      @(posedge clk);
      #1;
      exp_w = sb.pop_front();
      total++;
      if ({grant_valid, grant_idx, grant_onehot} !== exp_w)
        $display("FAIL rotation[%0d]: got %h want %h", i, {grant_valid, grant_idx, grant_onehot}, exp_w);
      else passed++;
    end
    req = 8'h00;
    sb.push_back(ex(1'b0, 3'd0));
    @(posedge clk);
    #1;
    exp_w = sb.pop_front();
    total++;
    if ({grant_valid, grant_idx, grant_onehot} !== exp_w)
      $display("FAIL rotation_drain: got %h want %h", {grant_valid, grant_idx, grant_onehot}, exp_w);
    else passed++;
  endtask

  task automatic test_backpressure();
    logic [7:0] reqs [8] = '{8'h24, 8'h24, 8'h24, 8'h24, 8'h24, 8'h20, 8'h20, 8'h00};
    logic       rdys [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       vals [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [2:0] idxs [8] = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd5, 3'd0};
    pulse_reset();
    for (int i = 0; i < 8; i++) begin
      req         = reqs[i];
      grant_ready = rdys[i];
      sb.push_back(ex(vals[i], idxs[i]));
      @(posedge clk);
      #1;
      exp_w = sb.pop_front();
      total++;
      if ({grant_valid, grant_idx, grant_onehot} !== exp_w)
        $display("FAIL backpressure[%0d]: got %h want %h", i, {grant_valid, grant_idx, grant_onehot}, exp_w);
      else passed++;
    end
  endtask

  task automatic test_wrap();
    logic [7:0] reqs [4] = '{8'h40, 8'h00, 8'h01, 8'h00};
    logic       rdys [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic       vals [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0] idxs [4] = '{3'd6, 3'd0, 3'd0, 3'd0};
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      req         = reqs[i];
      grant_ready = rdys[i];
      sb.push_back(ex(vals[i], idxs[i]));
      @(posedge clk);
      #1;
      exp_w = sb.pop_front();
      total++;
      if ({grant_valid, grant_idx, grant_onehot} !== exp_w)
        $display("FAIL wrap[%0d]: got %h want %h", i, {grant_valid, grant_idx, grant_onehot}, exp_w);
      else passed++;
    end
  endtask

  // Idle with ready high must not grant; a lone requester alternates grant/idle.
  task automatic test_empty_single();
    logic [7:0] reqs [9] = '{8'h00, 8'h00, 8'h00, 8'h08, 8'h08, 8'h08, 8'h08, 8'h08, 8'h08};
    logic       vals [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    pulse_reset();
    grant_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      req = reqs[i];
      sb.push_back(ex(vals[i], vals[i] ? 3'd3 : 3'd0));
      @(posedge clk);
      #1;
      exp_w = sb.pop_front();
      total++;
      if ({grant_valid, grant_idx, grant_onehot} !== exp_w)
        $display("FAIL empty_single[%0d]: got %h want %h", i, {grant_valid, grant_idx, grant_onehot}, exp_w);
      else passed++;
    end
    req = 8'h00;
    grant_ready = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_async_reset();
    pulse_reset();
    req         = 8'hFF;
    grant_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sb.push_back(ex(1'b1, 3'(i)));
      @(posedge clk);
      #1;
      exp_w = sb.pop_front();
      total++;
      if ({grant_valid, grant_idx, grant_onehot} !== exp_w)
        $display("FAIL async_setup[%0d]: got %h want %h", i, {grant_valid, grant_idx, grant_onehot}, exp_w);
      else passed++;
    end
    grant_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    sb.push_back(ex(1'b0, 3'd0));
    #1;
    exp_w = sb.pop_front();
    total++;
    if ({grant_valid, grant_idx, grant_onehot} !== exp_w)
      $display("FAIL async_clear: got %h want %h", {grant_valid, grant_idx, grant_onehot}, exp_w);
    else passed++;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    sb.push_back(ex(1'b1, 3'd0));
    @(posedge clk);
    #1;
    exp_w = sb.pop_front();
    total++;
    if ({grant_valid, grant_idx, grant_onehot} !== exp_w)
      $display("FAIL async_ptr_reset: got %h want %h", {grant_valid, grant_idx, grant_onehot}, exp_w);
    else passed++;
  endtask

  initial begin
    total       = 0;
    passed      = 0;
    reset_n     = 1'b0;
    req         = 8'h00;
    grant_ready = 1'b0;
    #2;
    test_reset();
    test_rotation();
    test_backpressure();
    test_wrap();
    test_empty_single();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
